// File: rtl/layernorm_feeder_if.sv
// layernorm_feeder_if: command, memory-read and engine-side signals of the
// layer-norm input feeder. The master modport is the feeder itself; the slave
// modport is the environment (command source, memories and engine).
interface layernorm_feeder_if #(
    parameter int BUS_NUM         = 8,
    parameter int DATA_NUM_WIDTH  = 10,
    parameter int SCALA_POS_WIDTH = 5,
    parameter int ADDR_WIDTH      = 8,
    parameter int sig_width       = 7,
    parameter int exp_width       = 8
);
    localparam int FW = sig_width + exp_width + 1;

    logic                          start;
    logic [DATA_NUM_WIDTH-1:0]     start_data_num;
    logic [ADDR_WIDTH-1:0]         start_base_addr;
    logic [SCALA_POS_WIDTH-1:0]    start_in_scale_pos;
    logic [SCALA_POS_WIDTH-1:0]    start_out_scale_pos;
    logic                          busy;
    logic                          done;

    logic                          act_rd_en;
    logic [ADDR_WIDTH-1:0]         act_rd_addr;
    logic [BUS_NUM*8-1:0]          act_rd_data;
    logic                          prm_rd_en;
    logic [ADDR_WIDTH-1:0]         prm_rd_addr;
    logic [BUS_NUM*FW-1:0]         prm_gamma_data;
    logic [BUS_NUM*FW-1:0]         prm_beta_data;

    logic [DATA_NUM_WIDTH-1:0]     ln_data_num;
    logic                          ln_data_num_vld;
    logic [SCALA_POS_WIDTH-1:0]    ln_in_scale_pos;
    logic                          ln_in_scale_pos_vld;
    logic [SCALA_POS_WIDTH-1:0]    ln_out_scale_pos;
    logic                          ln_out_scale_pos_vld;
    logic [BUS_NUM*8-1:0]          ln_fixed_data;
    logic [BUS_NUM-1:0]            ln_fixed_data_vld;
    logic [BUS_NUM*FW-1:0]         ln_gamma;
    logic [BUS_NUM*FW-1:0]         ln_beta;
    logic [BUS_NUM-1:0]            ln_gamma_vld;
    logic [BUS_NUM-1:0]            ln_beta_vld;
    logic                          ln_out_last;

    modport master (
        input  start, start_data_num, start_base_addr,
        input  start_in_scale_pos, start_out_scale_pos,
        output busy, done,
        output act_rd_en, act_rd_addr,
        input  act_rd_data,
        output prm_rd_en, prm_rd_addr,
        input  prm_gamma_data, prm_beta_data,
        output ln_data_num, ln_data_num_vld,
        output ln_in_scale_pos, ln_in_scale_pos_vld,
        output ln_out_scale_pos, ln_out_scale_pos_vld,
        output ln_fixed_data, ln_fixed_data_vld,
        output ln_gamma, ln_beta, ln_gamma_vld, ln_beta_vld,
        input  ln_out_last
    );

    modport slave (
        output start, start_data_num, start_base_addr,
        output start_in_scale_pos, start_out_scale_pos,
        input  busy, done,
        input  act_rd_en, act_rd_addr,
        output act_rd_data,
        input  prm_rd_en, prm_rd_addr,
        output prm_gamma_data, prm_beta_data,
        input  ln_data_num, ln_data_num_vld,
        input  ln_in_scale_pos, ln_in_scale_pos_vld,
        input  ln_out_scale_pos, ln_out_scale_pos_vld,
        input  ln_fixed_data, ln_fixed_data_vld,
        input  ln_gamma, ln_beta, ln_gamma_vld, ln_beta_vld,
        output ln_out_last
    );
endinterface

// File: rtl/layernorm_feeder.sv
// layernorm_feeder: sends the vector configuration to the layer-norm engine,
// streams one activation row as BUS_NUM-lane beats with lane masks, then holds
// off until the engine reports its last output beat.
// Optional feature macro: LN_FEEDER_GAMMA_BETA_EN (also stream gamma/beta
// parameter beats alongside the activation beats).
//
// state  | meaning
// IDLE   | waiting for start; done pulse of the previous command may be out
// CFG    | config valids out, read of beat 0 issued
// STREAM | one read per cycle for beats 1..NBEAT-1
// WAIT   | all reads issued, waiting for the engine's last output beat
module layernorm_feeder #(
    parameter int BUS_NUM         = 8,
    parameter int DATA_NUM_WIDTH  = 10,
    parameter int SCALA_POS_WIDTH = 5,
    parameter int ADDR_WIDTH      = 8,
    parameter int sig_width       = 7,
    parameter int exp_width       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    layernorm_feeder_if.master bus
);
    localparam int FW  = sig_width + exp_width + 1;
    localparam int DW  = DATA_NUM_WIDTH;
    localparam int SPW = SCALA_POS_WIDTH;
    localparam int AW  = ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM, S_WAIT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DW-1:0]          r_data_num;
    logic [AW-1:0]          r_base;
    logic [SPW-1:0]         r_in_pos;
    logic [SPW-1:0]         r_out_pos;
    logic [BUS_NUM-1:0]     r_last_mask;
    logic [DW-1:0]          r_rem;
    logic [DW-1:0]          r_k;
    logic                   r_last_seen;
    logic                   r_done;
    logic                   r_done_busy;
    logic                   r_pend;
    logic [BUS_NUM-1:0]     r_pend_mask;
    logic [BUS_NUM*8-1:0]   r_ln_data;
    logic [BUS_NUM-1:0]     r_ln_vld;

    logic                   w_start_acc;
    logic                   w_start_zero;
    logic [DW:0]            w_nbeat_sum;
    logic [DW:0]            w_nbeat_shf;
    logic [DW-1:0]          w_rem_init;
    logic [DW-1:0]          w_n_m1;
    logic [DW-1:0]          w_lane_idx;
    logic [BUS_NUM-1:0]     w_last_mask;
    logic                   w_exit_wait;
    logic                   w_issue;
    logic                   w_cfg;
    logic                   w_busy;
    logic [AW-1:0]          w_act_addr;

    // The done cycle of a real command still counts as busy, so start is
    // only taken once that cycle has passed.
    assign w_start_acc  = bus.start && (r_state == S_IDLE) && !r_done_busy;
    assign w_start_zero = w_start_acc && (bus.start_data_num == '0);

    // Remaining-read down-counter starts at NBEAT-1 so the terminal count
    // marks the read of the final beat.
    assign w_nbeat_sum  = {1'b0, bus.start_data_num} + (DW+1)'(BUS_NUM - 1);
    assign w_nbeat_shf  = w_nbeat_sum >> $clog2(BUS_NUM);
    assign w_rem_init   = w_nbeat_shf[DW-1:0] - DW'(1);

    // Last beat carries lanes 0..R-1 where R-1 = (N-1) mod BUS_NUM.
    assign w_n_m1       = bus.start_data_num - DW'(1);
    assign w_lane_idx   = w_n_m1 & DW'(BUS_NUM - 1);

    // Lane mask of the final beat, derived from the incoming element count
    always_comb begin
        w_last_mask = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            w_last_mask[i] = (DW'(i) <= w_lane_idx);
        end
    end

    assign w_exit_wait = (r_state == S_WAIT) && (bus.ln_out_last || r_last_seen);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc && !w_start_zero) begin
                    w_state_nxt = S_CFG;
                end
            end
            S_CFG, S_STREAM: begin
                w_state_nxt = (r_rem == '0) ? S_WAIT : S_STREAM;
            end
            S_WAIT: begin
                if (w_exit_wait) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_issue    = (r_state == S_CFG) || (r_state == S_STREAM);
        w_cfg      = (r_state == S_CFG);
        w_busy     = (r_state != S_IDLE) || r_done_busy;
        w_act_addr = w_issue ? (r_base + AW'(r_k)) : '0;
    end

    // Command capture, read index and remaining-read counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_num  <= '0;
            r_base      <= '0;
            r_in_pos    <= '0;
            r_out_pos   <= '0;
            r_last_mask <= '0;
            r_rem       <= '0;
            r_k         <= '0;
        end else if (w_start_acc) begin
            r_data_num  <= bus.start_data_num;
            r_base      <= bus.start_base_addr;
            r_in_pos    <= bus.start_in_scale_pos;
            r_out_pos   <= bus.start_out_scale_pos;
            r_last_mask <= w_last_mask;
            r_rem       <= w_rem_init;
            r_k         <= '0;
        end else if (w_issue) begin
            r_k <= r_k + DW'(1);
            if (r_rem != '0) begin
                r_rem <= r_rem - DW'(1);
            end
        end
    end

    // Early last-beat flag, done pulse and the busy extension over done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_seen <= 1'b0;
            r_done      <= 1'b0;
            r_done_busy <= 1'b0;
        end else begin
            if (w_state_nxt == S_IDLE) begin
                r_last_seen <= 1'b0;
            end else if (w_issue && bus.ln_out_last) begin
                r_last_seen <= 1'b1;
            end
            r_done      <= w_start_zero || w_exit_wait;
            r_done_busy <= w_exit_wait;
        end
    end

    // Track which issued read returns next cycle and its lane mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_mask <= '0;
        end else begin
            r_pend      <= w_issue;
            r_pend_mask <= (r_rem == '0) ? r_last_mask : '1;
        end
    end

    // Register returned activation data onto the engine bus
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ln_data <= '0;
            r_ln_vld  <= '0;
        end else begin
            r_ln_data <= r_pend ? bus.act_rd_data : '0;
            r_ln_vld  <= r_pend ? r_pend_mask : '0;
        end
    end

    assign bus.busy                 = w_busy;
    assign bus.done                 = r_done;
    assign bus.act_rd_en            = w_issue;
    assign bus.act_rd_addr          = w_act_addr;
    assign bus.ln_data_num          = w_cfg ? r_data_num : '0;
    assign bus.ln_data_num_vld      = w_cfg;
    assign bus.ln_in_scale_pos      = w_cfg ? r_in_pos : '0;
    assign bus.ln_in_scale_pos_vld  = w_cfg;
    assign bus.ln_out_scale_pos     = w_cfg ? r_out_pos : '0;
    assign bus.ln_out_scale_pos_vld = w_cfg;
    assign bus.ln_fixed_data        = r_ln_data;
    assign bus.ln_fixed_data_vld    = r_ln_vld;

`ifdef LN_FEEDER_GAMMA_BETA_EN
    logic [BUS_NUM*FW-1:0] r_ln_gamma;
    logic [BUS_NUM*FW-1:0] r_ln_beta;

    // Parameter words follow the same one-cycle return and register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ln_gamma <= '0;
            r_ln_beta  <= '0;
        end else begin
            r_ln_gamma <= r_pend ? bus.prm_gamma_data : '0;
            r_ln_beta  <= r_pend ? bus.prm_beta_data : '0;
        end
    end

    assign bus.prm_rd_en    = w_issue;
    assign bus.prm_rd_addr  = w_issue ? AW'(r_k) : '0;
    assign bus.ln_gamma     = r_ln_gamma;
    assign bus.ln_beta      = r_ln_beta;
    assign bus.ln_gamma_vld = r_ln_vld;
    assign bus.ln_beta_vld  = r_ln_vld;
`else
    // Gamma/beta are loaded by another agent; parameter data is ignored.
    logic w_unused_prm;
    assign w_unused_prm     = ^{bus.prm_gamma_data, bus.prm_beta_data};

    assign bus.prm_rd_en    = 1'b0;
    assign bus.prm_rd_addr  = '0;
    assign bus.ln_gamma     = '0;
    assign bus.ln_beta      = '0;
    assign bus.ln_gamma_vld = '0;
    assign bus.ln_beta_vld  = '0;
`endif

endmodule

// File: tb/tb_layernorm_feeder.sv
// Testbench for layernorm_feeder: directed scenarios plus randomized commands
// checked against a cycle-level reference model built from element count,
// base address and engine last-beat timing.
module tb_layernorm_feeder;
    localparam int BUS  = 8;
    localparam int DW   = 10;
    localparam int SPW  = 5;
    localparam int AW   = 8;
    localparam int SW   = 7;
    localparam int EW   = 8;
    localparam int FW   = SW + EW + 1;
    localparam int WMAX = 256;
`ifdef LN_FEEDER_GAMMA_BETA_EN
    localparam bit GB = 1'b1;
`else
    localparam bit GB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layernorm_feeder_if #(.BUS_NUM(BUS), .DATA_NUM_WIDTH(DW), .SCALA_POS_WIDTH(SPW),
                          .ADDR_WIDTH(AW), .sig_width(SW), .exp_width(EW)) bus ();

    layernorm_feeder #(.BUS_NUM(BUS), .DATA_NUM_WIDTH(DW), .SCALA_POS_WIDTH(SPW),
                       .ADDR_WIDTH(AW), .sig_width(SW), .exp_width(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [BUS*8-1:0]  act_mem [256];
    logic [BUS*FW-1:0] g_mem   [256];
    logic [BUS*FW-1:0] b_mem   [256];

    // one-cycle-latency memories
    always @(posedge clk) begin
        if (bus.act_rd_en) bus.act_rd_data <= act_mem[bus.act_rd_addr];
        if (bus.prm_rd_en) begin
            bus.prm_gamma_data <= g_mem[bus.prm_rd_addr];
            bus.prm_beta_data  <= b_mem[bus.prm_rd_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // observed trace, indexed by cycle after the start edge
    logic              o_rd_en [WMAX];
    logic [AW-1:0]     o_rd_addr [WMAX];
    logic              o_prm_en [WMAX];
    logic [AW-1:0]     o_prm_addr [WMAX];
    logic [2:0]        o_cfg [WMAX];
    logic [DW-1:0]     o_dn [WMAX];
    logic [SPW-1:0]    o_ip [WMAX];
    logic [SPW-1:0]    o_op [WMAX];
    logic [BUS-1:0]    o_vld [WMAX];
    logic [BUS*8-1:0]  o_data [WMAX];
    logic [BUS-1:0]    o_gv [WMAX];
    logic [BUS-1:0]    o_bv [WMAX];
    logic [BUS*FW-1:0] o_g [WMAX];
    logic [BUS*FW-1:0] o_b [WMAX];
    logic              o_done [WMAX];
    logic              o_busy [WMAX];
    logic              o_any [WMAX];

    // expected trace from the reference model
    logic              e_rd_en [WMAX];
    logic [AW-1:0]     e_rd_addr [WMAX];
    logic              e_prm_en [WMAX];
    logic [AW-1:0]     e_prm_addr [WMAX];
    logic [2:0]        e_cfg [WMAX];
    logic [DW-1:0]     e_dn [WMAX];
    logic [SPW-1:0]    e_ip [WMAX];
    logic [SPW-1:0]    e_op [WMAX];
    logic [BUS-1:0]    e_vld [WMAX];
    logic [BUS*8-1:0]  e_data [WMAX];
    logic [BUS-1:0]    e_gv [WMAX];
    logic [BUS*FW-1:0] e_g [WMAX];
    logic [BUS*FW-1:0] e_b [WMAX];
    logic              e_done [WMAX];
    logic              e_busy [WMAX];

    function automatic logic outs_nonzero();
        return |{bus.busy, bus.done, bus.act_rd_en, bus.act_rd_addr, bus.prm_rd_en,
                 bus.prm_rd_addr, bus.ln_data_num, bus.ln_data_num_vld, bus.ln_in_scale_pos,
                 bus.ln_in_scale_pos_vld, bus.ln_out_scale_pos, bus.ln_out_scale_pos_vld,
                 bus.ln_fixed_data, bus.ln_fixed_data_vld, bus.ln_gamma, bus.ln_beta,
                 bus.ln_gamma_vld, bus.ln_beta_vld};
    endfunction

    // Start edge E0, then record cycles C1..C(win) sampled at the falling edge.
    task automatic run_cmd(input int n, input int base, input int ip, input int op,
                           input int last_cyc, input int start2_cyc, input int n2,
                           input int rst_cyc, input int win);
        for (int c = 0; c < WMAX; c++) begin
            o_rd_en[c] = 0; o_prm_en[c] = 0; o_cfg[c] = 0; o_vld[c] = 0;
            o_done[c] = 0; o_busy[c] = 0; o_any[c] = 0; o_gv[c] = 0; o_bv[c] = 0;
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.start_data_num = DW'(n);
        bus.start_base_addr = AW'(base);
        bus.start_in_scale_pos = SPW'(ip);
        bus.start_out_scale_pos = SPW'(op);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.start_data_num = DW'($urandom);
        bus.start_base_addr = AW'($urandom);
        bus.start_in_scale_pos = SPW'($urandom);
        bus.start_out_scale_pos = SPW'($urandom);
        for (int c = 1; c <= win; c++) begin
            bus.ln_out_last = (c == last_cyc);
            bus.start = (c == start2_cyc);
            if (c == start2_cyc) bus.start_data_num = DW'(n2);
            rst_n = (c != rst_cyc);
            @(negedge clk);
            o_rd_en[c] = bus.act_rd_en;   o_rd_addr[c] = bus.act_rd_addr;
            o_prm_en[c] = bus.prm_rd_en;  o_prm_addr[c] = bus.prm_rd_addr;
            o_cfg[c] = {bus.ln_data_num_vld, bus.ln_in_scale_pos_vld, bus.ln_out_scale_pos_vld};
            o_dn[c] = bus.ln_data_num;    o_ip[c] = bus.ln_in_scale_pos;
            o_op[c] = bus.ln_out_scale_pos;
            o_vld[c] = bus.ln_fixed_data_vld; o_data[c] = bus.ln_fixed_data;
            o_gv[c] = bus.ln_gamma_vld;   o_bv[c] = bus.ln_beta_vld;
            o_g[c] = bus.ln_gamma;        o_b[c] = bus.ln_beta;
            o_done[c] = bus.done;         o_busy[c] = bus.busy;
            o_any[c] = outs_nonzero();
            @(posedge clk); #1;
        end
        bus.ln_out_last = 1'b0;
        bus.start = 1'b0;
        rst_n = 1'b1;
    endtask

    // Reference: beat k covers elements k*BUS.., read in C1+k, shown in C3+k;
    // WAIT begins after the last read, done follows the last-beat report.
    task automatic model_cmd(input int n, input int base, input int ip, input int op,
                             input int last_cyc, output int dc);
        int nb, lanes, a;
        logic [BUS-1:0] mask;
        for (int c = 0; c < WMAX; c++) begin
            e_rd_en[c] = 0; e_rd_addr[c] = 0; e_prm_en[c] = 0; e_prm_addr[c] = 0;
            e_cfg[c] = 0; e_dn[c] = 0; e_ip[c] = 0; e_op[c] = 0; e_vld[c] = 0;
            e_data[c] = 0; e_gv[c] = 0; e_g[c] = 0; e_b[c] = 0; e_done[c] = 0; e_busy[c] = 0;
        end
        if (n == 0) begin
            e_done[1] = 1'b1;
            dc = 1;
            return;
        end
        nb = (n + BUS - 1) / BUS;
        e_cfg[1] = 3'b111; e_dn[1] = DW'(n); e_ip[1] = SPW'(ip); e_op[1] = SPW'(op);
        for (int k = 0; k < nb; k++) begin
            a = (base + k) % 256;
            e_rd_en[1+k] = 1'b1;
            e_rd_addr[1+k] = AW'(a);
            e_prm_en[1+k] = GB;
            e_prm_addr[1+k] = GB ? AW'(k) : '0;
            lanes = n - k * BUS;
            if (lanes > BUS) lanes = BUS;
            mask = '0;
            for (int l = 0; l < lanes; l++) mask[l] = 1'b1;
            e_vld[3+k] = mask;
            e_data[3+k] = act_mem[a];
            e_gv[3+k] = GB ? mask : '0;
            e_g[3+k] = g_mem[k % 256];
            e_b[3+k] = b_mem[k % 256];
        end
        dc = (last_cyc <= nb) ? nb + 2 : last_cyc + 1;
        e_done[dc] = 1'b1;
        for (int c = 1; c <= dc; c++) e_busy[c] = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.start_data_num = DW'(16);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (outs_nonzero() !== 1'b0) begin
                n_err++; $display("FAIL reset_outputs cyc=%0d got nonzero exp all zero", i);
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (outs_nonzero() !== 1'b0) begin
            n_err++; $display("FAIL reset_release got nonzero exp all zero");
        end
    endtask

    task automatic test_basic();
        run_cmd(16, 'h10, 3, -2, 10, 0, 0, 0, 14);
        n_vec++; if (o_cfg[1] !== 3'b111 || o_dn[1] !== DW'(16)) begin
            n_err++; $display("FAIL basic_cfg got vld=%b n=%0d exp 111 n=16", o_cfg[1], o_dn[1]); end
        n_vec++; if (o_ip[1] !== SPW'(3) || o_op[1] !== SPW'(-2)) begin
            n_err++; $display("FAIL basic_pos got %0d/%0d exp 3/-2", o_ip[1], o_op[1]); end
        n_vec++; if ({o_rd_en[1], o_rd_addr[1], o_rd_en[2], o_rd_addr[2], o_rd_en[3]} !== {1'b1, 8'h10, 1'b1, 8'h11, 1'b0}) begin
            n_err++; $display("FAIL basic_reads got %b:%h %b:%h %b exp 1:10 1:11 0",
                              o_rd_en[1], o_rd_addr[1], o_rd_en[2], o_rd_addr[2], o_rd_en[3]); end
        n_vec++; if ({o_vld[2], o_vld[3], o_vld[4], o_vld[5]} !== {8'h00, 8'hFF, 8'hFF, 8'h00}) begin
            n_err++; $display("FAIL basic_masks got %h %h %h %h exp 00 ff ff 00", o_vld[2], o_vld[3], o_vld[4], o_vld[5]); end
        n_vec++; if (o_data[3] !== act_mem[8'h10] || o_data[4] !== act_mem[8'h11]) begin
            n_err++; $display("FAIL basic_data got %h %h exp %h %h", o_data[3], o_data[4], act_mem[8'h10], act_mem[8'h11]); end
        n_vec++; if ({o_done[10], o_done[11], o_done[12]} !== 3'b010) begin
            n_err++; $display("FAIL basic_done got %b exp 010", {o_done[10], o_done[11], o_done[12]}); end
        n_vec++; if ({o_busy[1], o_busy[11], o_busy[12]} !== 3'b110) begin
            n_err++; $display("FAIL basic_busy got %b exp 110", {o_busy[1], o_busy[11], o_busy[12]}); end
        n_vec++; if (o_gv[3] !== (GB ? 8'hFF : 8'h00) || o_prm_en[1] !== GB) begin
            n_err++; $display("FAIL basic_gb_vld got gv=%h pen=%b exp gv=%h pen=%b", o_gv[3], o_prm_en[1], GB ? 8'hFF : 8'h00, GB); end
        n_vec++; if (o_g[3] !== (GB ? g_mem[0] : '0) || o_b[4] !== (GB ? b_mem[1] : '0)) begin
            n_err++; $display("FAIL basic_gb_data got %h %h", o_g[3], o_b[4]); end
    endtask

    task automatic test_partial();
        logic [BUS*FW-1:0] gm;
        gm = '0;
        for (int l = 0; l < 5; l++) gm[l*FW +: FW] = {FW{1'b1}};
        run_cmd(13, 'h40, 0, 0, 7, 0, 0, 0, 10);
        n_vec++; if (o_vld[3] !== 8'hFF || o_vld[4] !== 8'h1F) begin
            n_err++; $display("FAIL partial_masks got %h %h exp ff 1f", o_vld[3], o_vld[4]); end
        n_vec++; if ((o_data[4] & 64'h000000FF_FFFFFFFF) !== (act_mem[8'h41] & 64'h000000FF_FFFFFFFF)) begin
            n_err++; $display("FAIL partial_data got %h exp %h (lanes 0..4)", o_data[4], act_mem[8'h41]); end
        n_vec++; if (o_gv[4] !== (GB ? 8'h1F : 8'h00) || o_bv[3] !== (GB ? 8'hFF : 8'h00)) begin
            n_err++; $display("FAIL partial_gb_vld got %h %h", o_gv[4], o_bv[3]); end
        n_vec++; if ((o_g[4] & gm) !== (GB ? (g_mem[1] & gm) : '0) || o_b[3] !== (GB ? b_mem[0] : '0)) begin
            n_err++; $display("FAIL partial_gb_data got %h %h", o_g[4], o_b[3]); end
        n_vec++; if (o_done[8] !== 1'b1) begin
            n_err++; $display("FAIL partial_done got %b exp 1", o_done[8]); end
    endtask

    task automatic test_wrap();
        run_cmd(24, 'hFF, 1, 1, 12, 0, 0, 0, 15);
        n_vec++; if ({o_rd_addr[1], o_rd_addr[2], o_rd_addr[3]} !== {8'hFF, 8'h00, 8'h01} || o_rd_en[4] !== 1'b0) begin
            n_err++; $display("FAIL wrap_addr got %h %h %h en4=%b exp ff 00 01 0",
                              o_rd_addr[1], o_rd_addr[2], o_rd_addr[3], o_rd_en[4]); end
        n_vec++; if (o_vld[5] !== 8'hFF || o_vld[6] !== 8'h00 || o_data[5] !== act_mem[1]) begin
            n_err++; $display("FAIL wrap_beats got %h %h data %h exp ff 00 %h", o_vld[5], o_vld[6], o_data[5], act_mem[1]); end
        n_vec++; if (o_done[13] !== 1'b1) begin
            n_err++; $display("FAIL wrap_done got %b exp 1", o_done[13]); end
    endtask

    task automatic test_zero();
        logic act;
        run_cmd(0, 'h33, 0, 0, 0, 0, 0, 0, 6);
        act = 1'b0;
        for (int c = 1; c <= 6; c++) act |= o_busy[c] | o_rd_en[c] | (|o_cfg[c]) | (|o_vld[c]) | o_prm_en[c];
        n_vec++; if (act !== 1'b0) begin
            n_err++; $display("FAIL zero_activity got 1 exp 0"); end
        n_vec++; if ({o_done[1], o_done[2]} !== 2'b10) begin
            n_err++; $display("FAIL zero_done got %b exp 10", {o_done[1], o_done[2]}); end
    endtask

    task automatic test_back_to_back();
        logic extra;
        run_cmd(40, 'h80, 2, 4, 3, 2, 16, 0, 10);
        n_vec++; if (o_dn[1] !== DW'(40) || o_rd_en[5] !== 1'b1 || o_rd_en[6] !== 1'b0) begin
            n_err++; $display("FAIL b2b_len got n=%0d en5=%b en6=%b exp 40 1 0", o_dn[1], o_rd_en[5], o_rd_en[6]); end
        n_vec++; if ({o_done[6], o_done[7]} !== 2'b01 || {o_busy[7], o_busy[8]} !== 2'b10) begin
            n_err++; $display("FAIL b2b_done got done=%b busy=%b exp 01 10",
                              {o_done[6], o_done[7]}, {o_busy[7], o_busy[8]}); end
        extra = 1'b0;
        for (int c = 2; c <= 10; c++) extra |= (|o_cfg[c]) | ((c >= 6) & o_rd_en[c]);
        n_vec++; if (extra !== 1'b0) begin
            n_err++; $display("FAIL b2b_ignored got second command activity exp none"); end
        n_vec++; if (o_vld[7] !== 8'hFF || o_data[7] !== act_mem[8'h84]) begin
            n_err++; $display("FAIL b2b_last_beat got %h %h exp ff %h", o_vld[7], o_data[7], act_mem[8'h84]); end
    endtask

    task automatic test_reset_mid();
        logic any_after, gb_any;
        run_cmd(32, 'h20, 0, 0, 0, 0, 0, 3, 8);
        any_after = 1'b0;
        gb_any = 1'b0;
        for (int c = 4; c <= 8; c++) any_after |= o_any[c];
        for (int c = 1; c <= 8; c++) gb_any |= o_prm_en[c] | (|o_gv[c]) | (|o_bv[c]);
        n_vec++; if (any_after !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs got nonzero after reset exp all zero"); end
        run_cmd(8, 'h50, 5, 6, 5, 0, 0, 0, 9);
        for (int c = 1; c <= 9; c++) gb_any |= o_prm_en[c] | (|o_gv[c]) | (|o_bv[c]);
        n_vec++; if (o_rd_addr[1] !== 8'h50 || o_vld[3] !== 8'hFF || o_data[3] !== act_mem[8'h50]) begin
            n_err++; $display("FAIL rstmid_restart got addr %h vld %h data %h exp 50 ff %h",
                              o_rd_addr[1], o_vld[3], o_data[3], act_mem[8'h50]); end
        n_vec++; if (o_done[6] !== 1'b1 || o_busy[7] !== 1'b0) begin
            n_err++; $display("FAIL rstmid_done got done6=%b busy7=%b exp 1 0", o_done[6], o_busy[7]); end
        n_vec++; if (gb_any !== GB) begin
            n_err++; $display("FAIL rstmid_gb got %b exp %b", gb_any, GB); end
    endtask

    task automatic test_random();
        int n, base, ip, op, nb, lc, dc, win;
        for (int it = 0; it < 25; it++) begin
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 1023)) : int'($urandom_range(1, 70));
            base = $urandom_range(0, 255);
            ip = $urandom_range(0, 31);
            op = $urandom_range(0, 31);
            nb = (n + BUS - 1) / BUS;
            lc = $urandom_range(1, nb + 5);
            model_cmd(n, base, ip, op, lc, dc);
            win = dc + 2;
            run_cmd(n, base, ip, op, lc, 0, 0, 0, win);
            for (int c = 1; c <= win; c++) begin
                n_vec++;
                if (o_busy[c] !== e_busy[c] || o_done[c] !== e_done[c]) begin
                    n_err++; $display("FAIL rand_status n=%0d c=%0d got busy=%b done=%b exp %b %b",
                                      n, c, o_busy[c], o_done[c], e_busy[c], e_done[c]); end
                n_vec++;
                if (o_cfg[c] !== e_cfg[c] || (e_cfg[c] != 0 && {o_dn[c], o_ip[c], o_op[c]} !== {e_dn[c], e_ip[c], e_op[c]})) begin
                    n_err++; $display("FAIL rand_cfg n=%0d c=%0d got %b %0d %0d %0d exp %b %0d %0d %0d",
                                      n, c, o_cfg[c], o_dn[c], o_ip[c], o_op[c], e_cfg[c], e_dn[c], e_ip[c], e_op[c]); end
                n_vec++;
                if (o_rd_en[c] !== e_rd_en[c] || (e_rd_en[c] && o_rd_addr[c] !== e_rd_addr[c])) begin
                    n_err++; $display("FAIL rand_read n=%0d c=%0d got %b:%h exp %b:%h",
                                      n, c, o_rd_en[c], o_rd_addr[c], e_rd_en[c], e_rd_addr[c]); end
                n_vec++;
                if (o_prm_en[c] !== e_prm_en[c] || (e_prm_en[c] && o_prm_addr[c] !== e_prm_addr[c])) begin
                    n_err++; $display("FAIL rand_prm n=%0d c=%0d got %b:%h exp %b:%h",
                                      n, c, o_prm_en[c], o_prm_addr[c], e_prm_en[c], e_prm_addr[c]); end
                n_vec++;
                if (o_vld[c] !== e_vld[c] || o_gv[c] !== e_gv[c] || o_bv[c] !== e_gv[c]) begin
                    n_err++; $display("FAIL rand_mask n=%0d c=%0d got %h %h %h exp %h %h %h",
                                      n, c, o_vld[c], o_gv[c], o_bv[c], e_vld[c], e_gv[c], e_gv[c]); end
                for (int l = 0; l < BUS; l++) begin
                    if (e_vld[c][l]) begin
                        n_vec++;
                        if (o_data[c][l*8 +: 8] !== e_data[c][l*8 +: 8]) begin
                            n_err++; $display("FAIL rand_data n=%0d c=%0d lane=%0d got %h exp %h",
                                              n, c, l, o_data[c][l*8 +: 8], e_data[c][l*8 +: 8]); end
                    end
                    if (e_gv[c][l]) begin
                        n_vec++;
                        if (o_g[c][l*FW +: FW] !== e_g[c][l*FW +: FW] || o_b[c][l*FW +: FW] !== e_b[c][l*FW +: FW]) begin
                            n_err++; $display("FAIL rand_gb n=%0d c=%0d lane=%0d got %h %h exp %h %h", n, c, l,
                                              o_g[c][l*FW +: FW], o_b[c][l*FW +: FW], e_g[c][l*FW +: FW], e_b[c][l*FW +: FW]); end
                    end
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.start_data_num = '0;
        bus.start_base_addr = '0;
        bus.start_in_scale_pos = '0;
        bus.start_out_scale_pos = '0;
        bus.ln_out_last = 1'b0;
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = {$urandom, $urandom};
            g_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            b_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        test_reset();
        test_basic();
        test_partial();
        test_wrap();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
